route_header_latch: RTL and testbench

//   Per-input-port stage directly upstream of the router's XY routing demux.

---
 rtl/route_header_latch.sv | 165 ++++++++++++++++
 tb/tb_route_header_latch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/route_header_latch.sv
// route_header_latch
//   Input-port stage feeding the XY routing demux. Flits are buffered in a
//   small FIFO; the destination X/Y of each packet is captured from its header
//   flit and held on target_x/target_y until the packet's tlast flit leaves,
//   so the demux select never moves mid-packet. This build carries tdata and
//   tlast; no TID/TDEST/TUSER sideband is present.
module route_header_latch #(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter int X_LSB         = 0,
  parameter int Y_LSB         = 2,
  localparam int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  localparam int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  // flits from link/core
  input  logic                           in_tvalid,
  output logic                           in_tready,
  input  logic [DATA_WIDTH-1:0]          in_tdata,
  input  logic                           in_tlast,
  // flits to routing demux
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic [DATA_WIDTH-1:0]          out_tdata,
  output logic                           out_tlast,
  // latched route of the packet currently at the head
  output logic [MAX_ROUTERS_X_WIDTH-1:0] target_x,
  output logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y,
  output logic                           route_valid
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  // FIFO storage: entry = {tdata, tlast}
  logic [ENTRY_W-1:0]             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_reg;
  logic [PTR_W-1:0]               rd_ptr_reg;
  logic [CNT_W-1:0]               count_reg;
  logic [CNT_W-1:0]               count_next;
  logic                           fifo_empty;
  logic                           wr_en;
  logic                           rd_en;
  logic [ENTRY_W-1:0]             head_entry;
  logic [DATA_WIDTH-1:0]          head_data;
  logic                           head_last;

  state_t                         state_reg;
  state_t                         state_next;
  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x_reg;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y_reg;
  logic                           latch_route;

  // Head of FIFO is read combinationally from registered storage.
  assign head_entry = fifo_mem[rd_ptr_reg];
  assign head_data  = head_entry[ENTRY_W-1:1];
  assign head_last  = head_entry[0];

  assign fifo_empty = (count_reg == '0);
  // A full FIFO refuses input even if the head drains this same cycle.
  assign in_tready  = (count_reg != FULL_COUNT);
  assign wr_en      = in_tvalid && in_tready;
  assign rd_en      = out_tvalid && out_tready;

  assign out_tdata  = head_data;
  assign out_tlast  = head_last;
  assign target_x   = target_x_reg;
  assign target_y   = target_y_reg;

  // Route is captured from the head flit only while waiting for a new packet.
  assign latch_route = (state_reg == IDLE) && !fifo_empty;

  // Flit storage write; contents need no reset since count gates visibility.
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_reg] <= {in_tdata, in_tlast};
    end
  end

  // Occupancy: simultaneous write and read leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!wr_en && rd_en) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Target registers change only on the IDLE->ROUTE transition.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      target_x_reg <= '0;
      target_y_reg <= '0;
    end else if (latch_route) begin
      target_x_reg <= head_data[X_LSB +: MAX_ROUTERS_X_WIDTH];
      target_y_reg <= head_data[Y_LSB +: MAX_ROUTERS_Y_WIDTH];
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: enter ROUTE on a buffered header, leave after the tlast beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = ROUTE;
        end
      end
      ROUTE: begin
        if (rd_en && head_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: forward flits only while a route is held.
  always_comb begin
    route_valid = 1'b0;
    out_tvalid  = 1'b0;
    if (state_reg == ROUTE) begin
      route_valid = 1'b1;
      out_tvalid  = !fifo_empty;
    end
  end

endmodule

// File: tb/tb_route_header_latch.sv
// tb_route_header_latch
//   Directed scenario tasks plus a randomized scoreboard run for
//   route_header_latch with default parameters (4x4 mesh, X at [1:0],
//   Y at [3:2], FIFO_DEPTH=4).
module tb_route_header_latch;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] in_tdata;
  logic        in_tlast;
  logic        out_tvalid;
  logic        out_tready;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic [1:0]  target_x;
  logic [1:0]  target_y;
  logic        route_valid;

  int checks = 0;
  int errors = 0;

  // stimulus source and captured output beats for directed runs
  logic [31:0] src_data[$];
  bit          src_last[$];
  logic [31:0] got_data[$];
  bit          got_last[$];
  logic [1:0]  got_tx[$];
  logic [1:0]  got_ty[$];
  int          got_cycle[$];
  bit          rv_trace[$];

  route_header_latch dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_tvalid   (in_tvalid),
    .in_tready   (in_tready),
    .in_tdata    (in_tdata),
    .in_tlast    (in_tlast),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .out_tdata   (out_tdata),
    .out_tlast   (out_tlast),
    .target_x    (target_x),
    .target_y    (target_y),
    .route_valid (route_valid)
  );

  always #5 aclk = ~aclk;

  task automatic clear_logs();
    src_data.delete(); src_last.delete();
    got_data.delete(); got_last.delete();
    got_tx.delete(); got_ty.delete();
    got_cycle.delete(); rv_trace.delete();
  endtask

  // Drives src queue flits (valid whenever available) for a fixed number of
  // cycles with constant out_tready; logs every output beat with its cycle.
  // Entered and left at 1 time unit after a rising edge.
  task automatic run(input int cycles, input bit ready);
    for (int i = 0; i < cycles; i++) begin
      bit in_hs;
      bit out_hs;
      if (src_data.size() > 0) begin
        in_tvalid = 1'b1;
        in_tdata  = src_data[0];
        in_tlast  = src_last[0];
      end else begin
        in_tvalid = 1'b0;
        in_tdata  = '0;
        in_tlast  = 1'b0;
      end
      out_tready = ready;
      rv_trace.push_back(route_valid);
      in_hs  = in_tvalid && in_tready;
      out_hs = out_tvalid && out_tready;
      if (out_hs) begin
        got_data.push_back(out_tdata);
        got_last.push_back(out_tlast);
        got_tx.push_back(target_x);
        got_ty.push_back(target_y);
        got_cycle.push_back(i);
        $display("  beat cycle=%0d data=%h last=%0d target=(%0d,%0d)",
                 i, out_tdata, out_tlast, target_x, target_y);
      end
      @(posedge aclk); #1;
      if (in_hs) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
      end
    end
    in_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    // power-on reset state
    #3;
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL por_out_tvalid: got %b expected 0", out_tvalid); end
    checks++; if (route_valid !== 1'b0) begin errors++; $display("FAIL por_route_valid: got %b expected 0", route_valid); end
    checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL por_in_tready: got %b expected 1", in_tready); end
    checks++; if ({target_x, target_y} !== 4'h0) begin errors++; $display("FAIL por_target: got (%0d,%0d) expected (0,0)", target_x, target_y); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // mid-packet reset with flits buffered and a route held
    clear_logs();
    src_data = '{32'hF, 32'h77, 32'h78};
    src_last = '{1'b0, 1'b0, 1'b1};
    run(4, 1'b0);
    checks++; if ({target_x, target_y} !== {2'd3, 2'd3}) begin errors++; $display("FAIL rst_pre_target: got (%0d,%0d) expected (3,3)", target_x, target_y); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_out_tvalid: got %b expected 0", out_tvalid); end
    checks++; if (route_valid !== 1'b0) begin errors++; $display("FAIL rst_route_valid: got %b expected 0", route_valid); end
    checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL rst_in_tready: got %b expected 1", in_tready); end
    checks++; if ({target_x, target_y} !== 4'h0) begin errors++; $display("FAIL rst_target: got (%0d,%0d) expected (0,0)", target_x, target_y); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // first flit after reset is a header; old flits are gone
    clear_logs();
    src_data = '{32'h9};
    src_last = '{1'b1};
    run(6, 1'b1);
    checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL rst_beats: got %0d expected 1", got_data.size()); end
    checks++; if (got_data[0] !== 32'h9) begin errors++; $display("FAIL rst_data: got %h expected 00000009", got_data[0]); end
    checks++; if ({got_tx[0], got_ty[0]} !== {2'd1, 2'd2}) begin errors++; $display("FAIL rst_new_target: got (%0d,%0d) expected (1,2)", got_tx[0], got_ty[0]); end
  endtask

  task automatic test_three_flit();
    logic [31:0] ed [3] = '{32'hE, 32'h11, 32'h22};
    bit          el [3] = '{1'b0, 1'b0, 1'b1};
    clear_logs();
    src_data = '{32'hE, 32'h11, 32'h22};
    src_last = '{1'b0, 1'b0, 1'b1};
    run(8, 1'b1);
    checks++; if (got_data.size() !== 3) begin errors++; $display("FAIL t3f_beats: got %0d expected 3", got_data.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got_data[k] !== ed[k]) begin errors++; $display("FAIL t3f_data[%0d]: got %h expected %h", k, got_data[k], ed[k]); end
      checks++; if (got_last[k] !== el[k]) begin errors++; $display("FAIL t3f_last[%0d]: got %0d expected %0d", k, got_last[k], el[k]); end
      checks++; if (got_cycle[k] !== k + 2) begin errors++; $display("FAIL t3f_cycle[%0d]: got %0d expected %0d", k, got_cycle[k], k + 2); end
      checks++; if ({got_tx[k], got_ty[k]} !== {2'd2, 2'd3}) begin errors++; $display("FAIL t3f_target[%0d]: got (%0d,%0d) expected (2,3)", k, got_tx[k], got_ty[k]); end
    end
    checks++; if (rv_trace[1] !== 1'b0) begin errors++; $display("FAIL t3f_rv_c1: got %0d expected 0", rv_trace[1]); end
    checks++; if (rv_trace[2] !== 1'b1) begin errors++; $display("FAIL t3f_rv_c2: got %0d expected 1", rv_trace[2]); end
    checks++; if (rv_trace[5] !== 1'b0) begin errors++; $display("FAIL t3f_rv_c5: got %0d expected 0", rv_trace[5]); end
    checks++; if ({target_x, target_y} !== {2'd2, 2'd3}) begin errors++; $display("FAIL t3f_hold: got (%0d,%0d) expected (2,3)", target_x, target_y); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed [5] = '{32'h1, 32'hAA, 32'hBB, 32'hB, 32'hCC};
    bit          el [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          ec [5] = '{2, 3, 4, 6, 7};
    logic [1:0]  ex [5] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
    logic [1:0]  ey [5] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2};
    clear_logs();
    src_data = '{32'h1, 32'hAA, 32'hBB, 32'hB, 32'hCC};
    src_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run(12, 1'b1);
    checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL b2b_beats: got %0d expected 5", got_data.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (got_data[k] !== ed[k]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got_data[k], ed[k]); end
      checks++; if (got_last[k] !== el[k]) begin errors++; $display("FAIL b2b_last[%0d]: got %0d expected %0d", k, got_last[k], el[k]); end
      checks++; if (got_cycle[k] !== ec[k]) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", k, got_cycle[k], ec[k]); end
      checks++; if ({got_tx[k], got_ty[k]} !== {ex[k], ey[k]}) begin errors++; $display("FAIL b2b_target[%0d]: got (%0d,%0d) expected (%0d,%0d)", k, got_tx[k], got_ty[k], ex[k], ey[k]); end
    end
    checks++; if (rv_trace[5] !== 1'b0) begin errors++; $display("FAIL b2b_bubble: route_valid got %0d expected 0", rv_trace[5]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [5] = '{32'h6, 32'h101, 32'h102, 32'h103, 32'h104};
    clear_logs();
    src_data = '{32'h6, 32'h101, 32'h102, 32'h103, 32'h104};
    src_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run(8, 1'b0);
    checks++; if (src_data.size() !== 1) begin errors++; $display("FAIL bp_accepted: left %0d expected 1", src_data.size()); end
    checks++; if (in_tready !== 1'b0) begin errors++; $display("FAIL bp_full_tready: got %b expected 0", in_tready); end
    checks++; if (out_tvalid !== 1'b1) begin errors++; $display("FAIL bp_out_tvalid: got %b expected 1", out_tvalid); end
    checks++; if (out_tdata !== 32'h6) begin errors++; $display("FAIL bp_head_held: got %h expected 00000006", out_tdata); end
    run(12, 1'b1);
    checks++; if (got_data.size() !== 5) begin errors++; $display("FAIL bp_beats: got %0d expected 5", got_data.size()); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (got_data[k] !== ed[k]) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_data[k], ed[k]); end
      checks++; if ({got_tx[k], got_ty[k]} !== {2'd2, 2'd1}) begin errors++; $display("FAIL bp_target[%0d]: got (%0d,%0d) expected (2,1)", k, got_tx[k], got_ty[k]); end
    end
    checks++; if (got_last[4] !== 1'b1) begin errors++; $display("FAIL bp_last: got %0d expected 1", got_last[4]); end
    checks++; if (in_tready !== 1'b1) begin errors++; $display("FAIL bp_tready_back: got %b expected 1", in_tready); end
  endtask

  task automatic test_single_flit();
    bit erv [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    clear_logs();
    src_data = '{32'h5};
    src_last = '{1'b1};
    run(6, 1'b1);
    checks++; if (got_data.size() !== 1) begin errors++; $display("FAIL sf_beats: got %0d expected 1", got_data.size()); end
    checks++; if (got_cycle[0] !== 2) begin errors++; $display("FAIL sf_cycle: got %0d expected 2", got_cycle[0]); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL sf_last: got %0d expected 1", got_last[0]); end
    checks++; if ({got_tx[0], got_ty[0]} !== {2'd1, 2'd1}) begin errors++; $display("FAIL sf_target: got (%0d,%0d) expected (1,1)", got_tx[0], got_ty[0]); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (rv_trace[k] !== erv[k]) begin errors++; $display("FAIL sf_rv[%0d]: got %0d expected %0d", k, rv_trace[k], erv[k]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    logic [1:0]  exp_tx[$];
    logic [1:0]  exp_ty[$];
    bit          hold = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    int          pkts = 0;
    int          cyc = 0;
    int          local_err = 0;
    clear_logs();
    for (int p = 0; p < 1000; p++) begin
      int len = $urandom_range(1, 4);
      for (int f = 0; f < len; f++) begin
        logic [31:0] d = $urandom;
        src_data.push_back(d); src_last.push_back(f == len - 1);
        exp_data.push_back(d); exp_last.push_back(f == len - 1);
        if (f == 0) begin
          exp_tx.push_back(d[1:0]);
          exp_ty.push_back(d[3:2]);
        end
      end
    end
    while (exp_data.size() > 0 && cyc < 40000 && local_err < 20) begin
      bit in_hs;
      bit out_hs;
      if (!hold) begin
        in_tvalid = (src_data.size() > 0) && ($urandom_range(0, 9) < 7);
        in_tdata  = (src_data.size() > 0) ? src_data[0] : '0;
        in_tlast  = (src_data.size() > 0) ? src_last[0] : 1'b0;
      end
      out_tready = ($urandom_range(0, 9) < 7);
      if (prev_stall) begin
        checks++; if (out_tvalid !== 1'b1 || out_tdata !== prev_data) begin errors++; local_err++; $display("FAIL rnd_stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_tvalid, out_tdata, prev_data); end
      end
      in_hs  = in_tvalid && in_tready;
      out_hs = out_tvalid && out_tready;
      if (out_hs) begin
        checks++; if (out_tdata !== exp_data[0] || out_tlast !== exp_last[0]) begin errors++; local_err++; $display("FAIL rnd_data: got %h/%0d expected %h/%0d", out_tdata, out_tlast, exp_data[0], exp_last[0]); end
        checks++; if ({target_x, target_y} !== {exp_tx[0], exp_ty[0]} || route_valid !== 1'b1) begin errors++; local_err++; $display("FAIL rnd_target: got (%0d,%0d) rv=%b expected (%0d,%0d) rv=1", target_x, target_y, route_valid, exp_tx[0], exp_ty[0]); end
        if (exp_last[0]) begin
          $display("  packet %0d done target=(%0d,%0d)", pkts, exp_tx[0], exp_ty[0]);
          void'(exp_tx.pop_front());
          void'(exp_ty.pop_front());
          pkts++;
        end
        void'(exp_data.pop_front());
        void'(exp_last.pop_front());
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      hold = in_tvalid && !in_hs;
      @(posedge aclk); #1;
      cyc++;
      if (in_hs) begin
        void'(src_data.pop_front());
        void'(src_last.pop_front());
      end
    end
    in_tvalid = 1'b0;
    checks++; if (pkts !== 1000) begin errors++; $display("FAIL rnd_packets: got %0d expected 1000 (cycles %0d)", pkts, cyc); end
  endtask

  initial begin
    aresetn    = 1'b0;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;
    test_reset();
    test_three_flit();
    test_back_to_back();
    test_backpressure();
    test_single_flit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
